// File: rtl/mips_div_hilo.sv
// Purpose : iterative restoring divider with the architectural HI/LO registers (LO=quotient, HI=remainder).
// Latency : result written to HI/LO at the WIDTH+1th edge after the start edge; done pulses the cycle after.
// Backpr. : busy is the stall request; start/mthi/mtlo are ignored while busy, start beats mthi/mtlo in IDLE.
//
// Ports: clk, reset (sync, active-low); start/is_signed/a/b launch div/divu;
//        mthi/mtlo/wdata write HI/LO directly; busy/done/dz status; hi/lo architectural registers.
module mips_div_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quot, divisor, a_raw;
  logic             sign_q, sign_r;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dz_q;

  // Operand magnitudes; -2^(W-1) maps onto itself, which is the correct unsigned magnitude.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (is_signed && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

  // One restoring step: shift the next dividend bit into the remainder, trial-subtract.
  // Since rem < divisor, the W+1 bit difference has its MSB set exactly when it borrows.
  logic [WIDTH:0] trial, diff;
  assign trial = {rem, quot[WIDTH-1]};
  assign diff  = trial - {1'b0, divisor};

  logic [WIDTH-1:0] q_fin, r_fin;
  assign q_fin = sign_q ? ({WIDTH{1'b0}} - quot) : quot;
  assign r_fin = sign_r ? ({WIDTH{1'b0}} - rem)  : rem;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      a_raw   <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            divisor <= b_mag;
            quot    <= a_mag;
            rem     <= '0;
            cnt     <= '0;
            a_raw   <= a;
            sign_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r  <= is_signed & a[WIDTH-1];
            dz_q    <= (b == '0);
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        RUN: begin
          quot <= {quot[WIDTH-2:0], ~diff[WIDTH]};
          rem  <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
          cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        FIN: begin
          done_q <= 1'b1;
          // Divide by zero returns the MIPS-style all-ones quotient and the untouched dividend.
          if (dz_q) begin
            lo_q <= '1;
            hi_q <= a_raw;
          end else begin
            lo_q <= q_fin;
            hi_q <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_div_hilo.sv
module tb_mips_div_hilo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  mips_div_hilo #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Launch a divide and wait (bounded) for done. Returns edges from start edge to done
  // and the number of sampled cycles with busy high, counting the one right after the start edge.
  task automatic run_div(input logic s, input logic [31:0] av, input logic [31:0] bv,
                         output int edges, output int bcnt);
    @(negedge clk);
    is_signed = s; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    bcnt  = busy ? 1 : 0;
    while (edges < 100) begin
      @(negedge clk);
      edges++;
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL reset_dz got=%0b exp=0", dz); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    int e, bc;
    run_div(1'b1, 32'd8, 32'd2, e, bc);
    total++; if (e !== 33) begin bad++; $display("FAIL basic_latency got=%0d exp=33", e); end
    total++; if (bc !== 33) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=33", bc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%0b exp=0", busy); end
    total++; if (lo !== 32'd4) begin bad++; $display("FAIL basic_lo got=%h exp=4", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL basic_hi got=%h exp=0", hi); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL basic_dz got=%0b exp=0", dz); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%0b exp=0", done); end
    total++; if (lo !== 32'd4) begin bad++; $display("FAIL basic_lo_hold got=%h exp=4", lo); end
  endtask

  task automatic test_signs;
    int e, bc;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, e, bc);
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL neg_lo got=%h exp=fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL neg_hi got=%h exp=ffffffff", hi); end
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, e, bc);
    total++; if (lo !== 32'h0FFF_FFFF) begin bad++; $display("FAIL divu_lo got=%h exp=0fffffff", lo); end
    total++; if (hi !== 32'hF) begin bad++; $display("FAIL divu_hi got=%h exp=f", hi); end
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, e, bc);
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL negdiv_lo got=%h exp=fffffffd", lo); end
    total++; if (hi !== 32'd1) begin bad++; $display("FAIL negdiv_hi got=%h exp=1", hi); end
  endtask

  task automatic test_div_zero;
    int e, bc;
    run_div(1'b1, 32'h1234, 32'h0, e, bc);
    total++; if (e !== 33) begin bad++; $display("FAIL dz_latency got=%0d exp=33", e); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_s_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'h1234) begin bad++; $display("FAIL dz_s_hi got=%h exp=1234", hi); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz_s_flag got=%0b exp=1", dz); end
    run_div(1'b0, 32'h1234, 32'h0, e, bc);
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_u_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'h1234) begin bad++; $display("FAIL dz_u_hi got=%h exp=1234", hi); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz_u_flag got=%0b exp=1", dz); end
    run_div(1'b0, 32'd9, 32'd3, e, bc);
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL dz_clear got=%0b exp=0", dz); end
    total++; if (lo !== 32'd3) begin bad++; $display("FAIL dz_after_lo got=%h exp=3", lo); end
  endtask

  task automatic test_overflow;
    int e, bc;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e, bc);
    total++; if (e !== 33) begin bad++; $display("FAIL ovf_latency got=%0d exp=33", e); end
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL ovf_lo got=%h exp=80000000", lo); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL ovf_hi got=%h exp=0", hi); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL ovf_dz got=%0b exp=0", dz); end
  endtask

  task automatic test_ignore;
    int n;
    logic [31:0] lo_before;
    lo_before = lo;
    // start together with mthi: the write must be dropped.
    @(negedge clk);
    is_signed = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1; mthi = 1'b1; wdata = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    total++; if (hi === 32'h5555_5555) begin bad++; $display("FAIL start_beats_mthi got=%h exp=not 55555555", hi); end
    a = 32'd200; b = 32'd3; is_signed = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 5) begin start = 1'b1; a = 32'd1; b = 32'd1; end
      if (n == 6) start = 1'b0;
      if (n == 10) begin mtlo = 1'b1; wdata = 32'hDEAD_BEEF; end
      if (n == 11) begin
        mtlo = 1'b0;
        total++; if (lo !== lo_before) begin bad++; $display("FAIL mtlo_busy got=%h exp=%h", lo, lo_before); end
      end
      if (done) break;
    end
    total++; if (n !== 33) begin bad++; $display("FAIL ignore_latency got=%0d exp=33", n); end
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL ignore_lo got=%h exp=e", lo); end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL ignore_hi got=%h exp=2", hi); end
    @(negedge clk);
    mthi = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    mthi = 1'b0;
    total++; if (hi !== 32'hABCD) begin bad++; $display("FAIL mthi_idle got=%h exp=abcd", hi); end
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL mthi_lo_kept got=%h exp=e", lo); end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    total++; if (hi !== 32'h0BAD_F00D) begin bad++; $display("FAIL both_hi got=%h exp=0badf00d", hi); end
    total++; if (lo !== 32'h0BAD_F00D) begin bad++; $display("FAIL both_lo got=%h exp=0badf00d", lo); end
  endtask

  task automatic test_reset_abort;
    int e, bc, seen;
    @(negedge clk);
    is_signed = 1'b0; a = 32'd50; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL abort_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL abort_lo got=%h exp=0", lo); end
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    run_div(1'b1, 32'd9, 32'd3, e, bc);
    total++; if (lo !== 32'd3) begin bad++; $display("FAIL post_abort_lo got=%h exp=3", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL post_abort_hi got=%h exp=0", hi); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_ignore();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
